radix4_seq_multiplier: RTL

- Parametrised, iterative radix-4 (modified Booth) multiplier: one Booth digit (2 multiplier bits) retired per clock.
- Supports run-time signed/unsigned operation and a start/busy/done handshake.
- Sits beside the existing 16x16 high-radix multiplier as its general-width, handshaked successor for datapaths that issue operands on demand.

---
 rtl/radix4_seq_multiplier.sv | 121 ++++++++++++
 1 files changed

// File: rtl/radix4_seq_multiplier.sv
// Iterative radix-4 (modified Booth) multiplier: retires one Booth digit per clock.
// A start/busy/done handshake surrounds it; signed or unsigned operation is chosen per request.
module radix4_seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int ITER  = WIDTH / 2 + 1;
    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int MPL_W = EXT_W + 1;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     mcand_q, mcand_d;
    logic [MPL_W-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   out_q, out_d;

    logic [EXT_W-1:0]     x_ext, y_ext;
    logic [ACC_W-1:0]     mcand2, pp, acc_sum;
    logic                 unused_acc_top;

    // Both operands are widened by two bits so an unsigned value is never mistaken for a negative one.
    always_comb begin
        x_ext = signed_mode ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
        y_ext = signed_mode ? {{2{y[WIDTH-1]}}, y} : {2'b00, y};
    end

    // The multiplicand register is pre-shifted by two bits per digit, so the partial product needs no shifter.
    always_comb begin
        mcand2 = {mcand_q[ACC_W-2:0], 1'b0};
        pp     = '0;
        case (mplier_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand2;
            3'b100:         pp = ~mcand2 + 1'b1;
            3'b101, 3'b110: pp = ~mcand_q + 1'b1;
            default:        pp = '0;
        endcase
        acc_sum = acc_q + pp;
    end

    assign unused_acc_top = ^acc_sum[ACC_W-1:2*WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        out_d    = out_q;

        case (state_q)
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[ACC_W-3:0], 2'b00};
                mplier_d = {{2{mplier_q[MPL_W-1]}}, mplier_q[MPL_W-1:2]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = S_DONE;
                    out_d   = acc_sum[2*WIDTH-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Requests are honoured only when no operation is in flight (IDLE, or the DONE cycle).
        if ((state_q != S_RUN) && start) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{(ACC_W - EXT_W){x_ext[EXT_W-1]}}, x_ext};
            mplier_d = {y_ext, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            out_q    <= out_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign out  = out_q;

endmodule
